// File: rtl/mux41_pkg.sv
// Shared constants and state encoding for the 4:1 round-robin select path.
// Imported by the arbiter top and its pick logic.
package mux41_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// Requester and consumer handshake bundle for the shared 4:1 select path.
// The slave side is the arbiter; the master side is its environment.
interface mux41_rr_arbiter_if #(
  parameter int DATA_W = 2
);
  import mux41_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );

endinterface

// File: rtl/mux41.sv
// Plain 4:1 select: f follows x[y].
// Shared by the arbiter as its data path.
module mux41 #(
  parameter int W = 2
) (
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  input  logic [1:0]   y,
  output logic [W-1:0] f
);

  always_comb begin
    f = x0;
    unique case (y)
      2'd0: f = x0;
      2'd1: f = x1;
      2'd2: f = x2;
      2'd3: f = x3;
      default: f = x0;
    endcase
  end

endmodule

// File: rtl/mux41_rr_arbiter_pick.sv
// Combinational 4-way picker: first set request scanning up from ptr,
// or from index 0 when fixed priority is selected.
module rr_pick4
  import mux41_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic               fixed,
  output logic [SEL_W-1:0]   gnt_idx,
  output logic               any
);

  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] idx;

  assign base = fixed ? '0 : ptr;
  assign any  = |req;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = base + SEL_W'(k);
      if (req[idx]) gnt_idx = idx;
    end
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Four-requester arbiter driving a shared 4:1 select into a
// one-entry output register with full-throughput drain/load.
module mux41_rr_arbiter
  import mux41_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prio_fixed,
  output logic [CNT_W-1:0] grant_cnt,
  mux41_rr_arbiter_if.slave bus
);

  state_t            st_q, st_d;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  gnt;
  logic              any;
  logic              can_load;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  sel_q;

  rr_pick4 u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .fixed   (prio_fixed),
    .gnt_idx (gnt),
    .any     (any)
  );

  generate
    if (DATA_W == 2) begin : g_mux
      mux41 #(.W(DATA_W)) u_mux (
        .x0 (bus.req_data[0*DATA_W +: DATA_W]),
        .x1 (bus.req_data[1*DATA_W +: DATA_W]),
        .x2 (bus.req_data[2*DATA_W +: DATA_W]),
        .x3 (bus.req_data[3*DATA_W +: DATA_W]),
        .y  (gnt),
        .f  (sel_data)
      );
    end else begin : g_idx
      assign sel_data = bus.req_data[gnt*DATA_W +: DATA_W];
    end
  endgenerate

  // Gating on rst keeps req_ready quiet while reset is held.
  assign can_load = (st_q == ST_EMPTY) || bus.out_ready;
  assign accept   = can_load && any && !rst;

  always_comb begin
    st_d          = st_q;
    bus.req_ready = '0;
    if (accept) begin
      st_d               = ST_FULL;
      bus.req_ready[gnt] = 1'b1;
    end else if (st_q == ST_FULL && bus.out_ready) begin
      st_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_EMPTY;
      data_q    <= '0;
      sel_q     <= '0;
      rr_ptr    <= '0;
      grant_cnt <= '0;
    end else begin
      st_q <= st_d;
      if (accept) begin
        data_q    <= sel_data;
        sel_q     <= gnt;
        grant_cnt <= grant_cnt + 1'b1;
        if (!prio_fixed) rr_ptr <= gnt + 2'd1;
      end
    end
  end

  assign bus.out_valid = (st_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter: reset, RR saturation,
// backpressure, fixed priority, counter wrap and async reset.
module tb_mux41_rr_arbiter;
  import mux41_pkg::*;

  logic       clk;
  logic       rst;
  logic       prio_fixed;
  logic [7:0] grant_cnt;
  int         errs;
  int         checks;

  mux41_rr_arbiter_if #(.DATA_W(2)) bus ();

  mux41_rr_arbiter #(.DATA_W(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .prio_fixed (prio_fixed),
    .grant_cnt  (grant_cnt),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [1:0] sel,
                      input logic [1:0] data, input logic [7:0] cnt);
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'(4'b0001 << sel));
    tick();
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sel"}, 32'(bus.out_sel), 32'(sel));
    chk({tag, "_dat"}, 32'(bus.out_data), 32'(data));
    chk({tag, "_cnt"}, 32'(grant_cnt), 32'(cnt));
  endtask

  initial begin
    errs   = 0;
    checks = 0;

    // 1. reset with random inputs
    rst           = 1'b1;
    bus.req_valid = 4'($urandom);
    bus.req_data  = 8'($urandom);
    bus.out_ready = 1'($urandom);
    prio_fixed    = 1'($urandom);
    repeat (3) tick();
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_rdy", 32'(bus.req_ready), 32'd0);
    chk("rst_cnt", 32'(grant_cnt), 32'd0);

    bus.req_valid = 4'h0;
    bus.req_data  = {2'd3, 2'd2, 2'd1, 2'd0};
    bus.out_ready = 1'b1;
    prio_fixed    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 2. RR saturation, first grant from index 0
    bus.req_valid = 4'hF;
    #1;
    for (int i = 0; i < 8; i++)
      beat("rr", 2'(i % 4), 2'(i % 4), 8'(i + 1));

    // 3. backpressure on requester 2 (ptr is 0 here)
    bus.req_valid = 4'b0100;
    #1;
    beat("bp_ld", 2'd2, 2'd2, 8'd9);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", 32'(bus.req_ready), 32'd0);
      tick();
      chk("bp_hold", 32'({bus.out_valid, bus.out_sel}), 32'({1'b1, 2'd2}));
      chk("bp_cnt", 32'(grant_cnt), 32'd9);
    end
    bus.out_ready = 1'b1;
    #1;
    beat("bp_go", 2'd2, 2'd2, 8'd10);
    bus.req_valid = 4'h0;
    tick();
    chk("drain_vld", 32'(bus.out_valid), 32'd0);
    chk("drain_sel", 32'(bus.out_sel), 32'd2);

    // 4. fixed priority, ptr is 3 and must stay 3
    bus.req_data  = {2'd0, 2'd1, 2'd2, 2'd3};
    prio_fixed    = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    for (int i = 0; i < 4; i++)
      beat("fix", 2'd1, 2'd2, 8'(11 + i));
    prio_fixed    = 1'b0;
    bus.req_valid = 4'b0110;
    #1;
    beat("fix2rr", 2'd1, 2'd2, 8'd15);
    bus.req_valid = 4'h0;
    tick();

    // 5. counter wrap; ptr is 2 here
    bus.req_valid = 4'hF;
    repeat (240) tick();
    chk("wrap_pre", 32'(grant_cnt), 32'd255);
    beat("wrap", 2'd2, 2'd1, 8'd0);

    // 6. async reset while FULL under backpressure
    bus.out_ready = 1'b0;
    tick();
    chk("ar_full", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar_vld", 32'(bus.out_valid), 32'd0);
    chk("ar_rdy", 32'(bus.req_ready), 32'd0);
    chk("ar_cnt", 32'(grant_cnt), 32'd0);
    chk("ar_sel", 32'(bus.out_sel), 32'd0);
    bus.req_valid = 4'b1100;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    beat("ar_post", 2'd2, 2'd1, 8'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
